round_robin_arbiter: RTL

// - Shares one downstream resource between REQUESTERS masters using registered round-robin arbitration.
// - Priority is rotated by a pointer: the request vector is rotated right so the pointer sits at bit 0,
//   the first set bit is found, and the result is rotated back.
// - Sits in front of shared datapath units (rotators, ALUs, memory ports), one grant at a time, valid/ready.
//

---
 rtl/omnicores_arbitration_pkg.sv | 17 +
 rtl/rotate_right_dynamic.sv | 13 +
 rtl/round_robin_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/omnicores_arbitration_pkg.sv
// Shared types and helpers for the round-robin arbitration blocks.
package omnicores_arbitration_pkg;

  typedef enum logic {IDLE, GRANTED} arbiter_state_t;

  // Widest request vector the priority search handles; narrower vectors are zero-extended.
  localparam int MAX_REQUESTERS = 64;

  // Index of the lowest set bit, 0 when the vector is empty.
  function automatic int first_one_index(input logic [MAX_REQUESTERS-1:0] vector);
    first_one_index = 0;
    for (int i = MAX_REQUESTERS - 1; i >= 0; i--) begin
      if (vector[i]) first_one_index = i;
    end
  endfunction

endpackage

// File: rtl/rotate_right_dynamic.sv
// Rotates a vector right by a runtime amount; amount must be below WIDTH.
module rotate_right_dynamic #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]         data,
  input  logic [$clog2(WIDTH)-1:0] amount,
  output logic [WIDTH-1:0]         rotated
);

  // Shifting the doubled vector keeps the wrap modulo WIDTH, not modulo a power of two.
  assign rotated = WIDTH'({data, data} >> amount);

endmodule

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: one grant at a time to a shared resource, valid/ready accept.
//
// state   | meaning
// IDLE    | no grant presented; next request vector is arbitrated from pointer
// GRANTED | grant held until accept or withdrawal of the granted request
module round_robin_arbiter
  import omnicores_arbitration_pkg::*;
#(
  parameter int REQUESTERS = 4
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic [REQUESTERS-1:0]         requests,
  output logic [REQUESTERS-1:0]         grant,
  output logic                          grant_valid,
  output logic [$clog2(REQUESTERS)-1:0] grant_index,
  input  logic                          resource_ready
);

  localparam int INDEX_WIDTH = $clog2(REQUESTERS);
  localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(REQUESTERS - 1);

  arbiter_state_t state;

  logic                   accept;
  logic [INDEX_WIDTH-1:0] pointer;
  logic [INDEX_WIDTH-1:0] next_pointer;
  logic [INDEX_WIDTH-1:0] search_pointer;
  logic [INDEX_WIDTH-1:0] unrotate_amount;
  logic [INDEX_WIDTH-1:0] winner_index;
  logic [REQUESTERS-1:0]  masked_requests;
  logic [REQUESTERS-1:0]  search_requests;
  logic [REQUESTERS-1:0]  rotated_requests;
  logic [REQUESTERS-1:0]  rotated_winner;
  logic [REQUESTERS-1:0]  winner;

  assign accept          = grant_valid & resource_ready;
  assign next_pointer    = (grant_index == LAST_INDEX) ? '0 : grant_index + 1'b1;
  assign masked_requests = requests & ~grant;

  // On accept the next winner is searched from the advanced pointer so grants run back-to-back.
  assign search_pointer  = accept ? next_pointer : pointer;
  assign search_requests = accept ? masked_requests : requests;

  // Left rotation back by search_pointer, expressed as a right rotation modulo REQUESTERS.
  assign unrotate_amount = (search_pointer == '0) ? '0
                         : INDEX_WIDTH'(REQUESTERS) - search_pointer;

  rotate_right_dynamic #(.WIDTH(REQUESTERS)) u_rotate_requests (
    .data    (search_requests),
    .amount  (search_pointer),
    .rotated (rotated_requests)
  );

  always_comb begin
    rotated_winner = '0;
    if (|rotated_requests) begin
      rotated_winner = REQUESTERS'(1) << first_one_index(MAX_REQUESTERS'(rotated_requests));
    end
  end

  rotate_right_dynamic #(.WIDTH(REQUESTERS)) u_rotate_back (
    .data    (rotated_winner),
    .amount  (unrotate_amount),
    .rotated (winner)
  );

  assign winner_index = INDEX_WIDTH'(first_one_index(MAX_REQUESTERS'(winner)));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= IDLE;
      pointer     <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_index <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|requests) begin
            grant       <= winner;
            grant_valid <= 1'b1;
            grant_index <= winner_index;
            state       <= GRANTED;
          end
        end
        GRANTED: begin
          if (accept) begin
            pointer <= next_pointer;
            if (|masked_requests) begin
              grant       <= winner;
              grant_valid <= 1'b1;
              grant_index <= winner_index;
            end else begin
              grant       <= '0;
              grant_valid <= 1'b0;
              grant_index <= '0;
              state       <= IDLE;
            end
          end else if ((requests & grant) == '0) begin
            // Withdrawn before accept: drop the grant, keep the pointer.
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
